// File: rtl/send_port_arbiter_pkg.sv
// ============================================================================
//  Module      : send_port_arbiter_pkg
//  Description : Flit field layout helpers and FSM encoding for send_port_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package send_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int vc_bits_f(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    function automatic int dest_bits_f(input int num_recv);
        return $clog2(num_recv);
    endfunction

    // Flit layout, MSB first: {valid, tail, dest, vc, data}
    function automatic int flit_width_f(input int data_w, input int dest_bits, input int vc_bits);
        return 2 + data_w + dest_bits + vc_bits;
    endfunction

    function automatic int valid_bit_f(input int fw);
        return fw - 1;
    endfunction

    function automatic int tail_bit_f(input int fw);
        return fw - 2;
    endfunction

    function automatic int dest_lsb_f(input int data_w, input int vc_bits);
        return data_w + vc_bits;
    endfunction

    function automatic int vc_lsb_f(input int data_w);
        return data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/send_port_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Rotate-priority find-first: first set bit at or above base, wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] base,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(base) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/send_port_arbiter.sv
// ============================================================================
//  Module      : send_port_arbiter
//  Description : Packet-level round-robin arbiter of NUM_REQ requesters onto one
//                credit-gated send port. Optional statistics: SEND_PORT_ARBITER_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module send_port_arbiter
    import send_port_arbiter_pkg::*;
#(
    parameter  int NUM_REQ         = 4,
    parameter  int FLIT_DATA_WIDTH = 32,
    parameter  int NUM_VCS         = 2,
    parameter  int NUM_RECV        = 4,
    localparam int VC_BITS         = vc_bits_f(NUM_VCS),
    localparam int DEST_BITS       = dest_bits_f(NUM_RECV),
    localparam int FW              = flit_width_f(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*FW-1:0] req_flit,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [FW-1:0]         put_flit,
    output logic                  EN_put_flit,
    input  logic [NUM_VCS-1:0]    non_full_vcs,
    output logic                  EN_get_non_full_vcs
`ifdef SEND_PORT_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] stat_flits,
    output logic [15:0]           stat_stall_cycles
`endif
);

    localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VC_SPAN   = 1 << VC_BITS;
    localparam int VALID_BIT = valid_bit_f(FW);
    localparam int TAIL_BIT  = tail_bit_f(FW);
    localparam int VC_LSB    = vc_lsb_f(FLIT_DATA_WIDTH);

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_VCS-1:0] lock_vc_q, lock_vc_d;
    logic [FW-1:0]      put_flit_q, put_flit_d;
    logic               en_put_q, en_put_d;

    logic [FW-1:0]      flit_arr [NUM_REQ];
    logic [VC_SPAN-1:0] sendable_ext;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               accept;
    logic [FW-1:0]      sel_flit;
    logic [VC_BITS-1:0] sel_vc;

    // Zero-extended so an encoded VC beyond NUM_VCS reads as never sendable
    assign sendable_ext = VC_SPAN'(non_full_vcs & ~lock_vc_q);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        logic [VC_BITS-1:0] req_vc;
        assign flit_arr[gi] = req_flit[gi*FW +: FW];
        assign req_vc       = flit_arr[gi][VC_LSB +: VC_BITS];
        assign eligible[gi] = req_valid[gi] & flit_arr[gi][VALID_BIT] & sendable_ext[req_vc]
                            & ((state_q == ST_IDLE) | (owner_q == PW'(gi)));
    end

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req     (eligible),
        .base    (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_comb begin
        accept     = gnt_any & ~RESET;
        req_ready  = RESET ? '0 : gnt;
        sel_flit   = flit_arr[gnt_idx];
        sel_vc     = sel_flit[VC_LSB +: VC_BITS];
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_vc_d  = '0;
        put_flit_d = '0;
        en_put_d   = 1'b0;
        if (accept) begin
            put_flit_d = sel_flit;
            en_put_d   = 1'b1;
            for (int v = 0; v < NUM_VCS; v++) begin
                lock_vc_d[v] = (sel_vc == VC_BITS'(v));
            end
            if (sel_flit[TAIL_BIT]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            end else begin
                state_d = ST_LOCKED;
                owner_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_vc_q  <= '0;
            put_flit_q <= '0;
            en_put_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_vc_q  <= lock_vc_d;
            put_flit_q <= put_flit_d;
            en_put_q   <= en_put_d;
        end
    end

    assign put_flit            = put_flit_q;
    assign EN_put_flit         = en_put_q;
    assign EN_get_non_full_vcs = 1'b1;

`ifdef SEND_PORT_ARBITER_STATS_EN
    logic [15:0] flit_cnt_q [NUM_REQ];
    logic [15:0] flit_cnt_d [NUM_REQ];
    logic [15:0] stall_q, stall_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            flit_cnt_d[i] = flit_cnt_q[i];
            if (accept && gnt[i] && (flit_cnt_q[i] != 16'hFFFF)) begin
                flit_cnt_d[i] = flit_cnt_q[i] + 16'd1;
            end
        end
        stall_d = stall_q;
        if ((|req_valid) && !accept && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                flit_cnt_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                flit_cnt_q[i] <= flit_cnt_d[i];
            end
            stall_q <= stall_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_flits[gi*16 +: 16] = flit_cnt_q[gi];
    end
    assign stat_stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_send_port_arbiter.sv
// ============================================================================
//  Module      : tb_send_port_arbiter
//  Description : Self-checking bench for send_port_arbiter against a rule-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_send_port_arbiter;
    import send_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int FW = 37;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [N-1:0]      req_valid;
    logic [N*FW-1:0]   req_flit;
    logic [N-1:0]      req_ready;
    logic [FW-1:0]     put_flit;
    logic              EN_put_flit;
    logic [1:0]        non_full_vcs;
    logic              EN_get_non_full_vcs;
`ifdef SEND_PORT_ARBITER_STATS_EN
    logic [N*16-1:0]   stat_flits;
    logic [15:0]       stat_stall_cycles;
`endif

    send_port_arbiter dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .req_valid           (req_valid),
        .req_flit            (req_flit),
        .req_ready           (req_ready),
        .put_flit            (put_flit),
        .EN_put_flit         (EN_put_flit),
        .non_full_vcs        (non_full_vcs),
        .EN_get_non_full_vcs (EN_get_non_full_vcs)
`ifdef SEND_PORT_ARBITER_STATS_EN
        ,
        .stat_flits          (stat_flits),
        .stat_stall_cycles   (stat_stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    logic [FW-1:0] pq [N][$];
    logic [FW-1:0] out_log [$];
    logic [N-1:0]  kill;

    int            m_owner;
    int            m_rr;
    logic [1:0]    m_lock;
    logic [FW-1:0] exp_put;
    logic          exp_en;
    bit            put_chk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk_flit(input bit v, input bit t, input int dest,
                                              input int vc, input logic [31:0] data);
        logic [1:0] d2;
        d2 = dest[1:0];
        return {v, t, d2, vc[0], data};
    endfunction

    task automatic push_pkt(input int r, input int len, input int vc, input logic [31:0] base);
        for (int k = 0; k < len; k++) begin
            pq[r].push_back(mk_flit(1'b1, k == len - 1, r, vc, base + 32'(k)));
        end
    endtask

    task automatic drive();
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (pq[i].size() > 0);
            f = (pq[i].size() > 0) ? pq[i][0] : '0;
            if (kill[i]) f[FW-1] = 1'b0;
            req_flit[i*FW +: FW] = f;
        end
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        int            g;
        int            i;
        logic [FW-1:0] f;
        logic [N-1:0]  exp_ready;
        drive();
        @(negedge CLK);
        g = -1;
        if (!RESET) begin
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                f = req_flit[i*FW +: FW];
                if (g < 0 && (m_owner < 0 || m_owner == i) && req_valid[i] && f[FW-1]
                    && non_full_vcs[f[32]] && !m_lock[f[32]]) g = i;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("get_nfv_en", 64'(EN_get_non_full_vcs), 64'd1);
        if (put_chk) begin
            chk("put_en", 64'(EN_put_flit), 64'(exp_en));
            chk("put_flit", 64'(put_flit), 64'(exp_put));
        end
        if (EN_put_flit === 1'b1) out_log.push_back(put_flit);
        exp_en  = 1'b0;
        exp_put = '0;
        m_lock  = '0;
        if (RESET) begin
            m_owner = -1;
            m_rr    = 0;
        end else if (g >= 0) begin
            f       = req_flit[g*FW +: FW];
            exp_en  = 1'b1;
            exp_put = f;
            m_lock[f[32]] = 1'b1;
            if (f[FW-2]) begin
                m_owner = -1;
                m_rr    = (g + 1) % N;
            end else begin
                m_owner = g;
            end
            void'(pq[g].pop_front());
        end
        put_chk = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        run(n);
        RESET = 1'b0;
    endtask

    initial begin
        RESET        = 1'b1;
        req_valid    = '0;
        req_flit     = '0;
        non_full_vcs = 2'b11;
        kill         = '0;
        m_owner      = -1;
        m_rr         = 0;
        m_lock       = '0;
        exp_put      = '0;
        exp_en       = 1'b0;
        put_chk      = 1'b0;
        #1;
        do_reset(3);

        // Two-flit packet from req0, one-cycle latency, returns to IDLE
        out_log.delete();
        pq[0].push_back(mk_flit(1, 0, 1, 0, 32'hA));
        pq[0].push_back(mk_flit(1, 1, 1, 0, 32'hB));
        run(7);
        chk("p1_count", 64'(out_log.size()), 64'd2);
        if (out_log.size() == 2) begin
            chk("p1_flit0", 64'(out_log[0]), 64'(mk_flit(1, 0, 1, 0, 32'hA)));
            chk("p1_flit1", 64'(out_log[1]), 64'(mk_flit(1, 1, 1, 0, 32'hB)));
        end
        chk("p1_fsm_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // Two competing 3-flit packets on VC0: packet-level round-robin
        do_reset(1);
        out_log.delete();
        push_pkt(0, 3, 0, 32'h100);
        push_pkt(2, 3, 0, 32'h200);
        run(16);
        chk("p2_count", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk("p2_order", 64'(out_log[k][31:0]), 64'((k < 3) ? 32'h100 + k : 32'h200 + k - 3));
        end
        chk("p2_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);

        // Owner stalls on a full VC; other requester must not sneak in
        out_log.delete();
        push_pkt(1, 3, 1, 32'h300);
        run(1);
        push_pkt(3, 1, 0, 32'h400);
        non_full_vcs = 2'b01;
        run(5);
        non_full_vcs = 2'b11;
        run(10);
        chk("p3_count", 64'(out_log.size()), 64'd4);
        if (out_log.size() == 4) begin
            chk("p3_resume", 64'(out_log[2][31:0]), 64'h302);
            chk("p3_last", 64'(out_log[3][31:0]), 64'h400);
        end

        // Back-to-back single-flit packets on VC0 with VC1 interleaving
        for (int k = 0; k < 4; k++) push_pkt(0, 1, 0, 32'h500 + 32'(k));
        for (int k = 0; k < 2; k++) push_pkt(1, 1, 1, 32'h600 + 32'(k));
        run(12);

        // Reset one cycle after a non-tail accept
        do_reset(1);
        push_pkt(2, 2, 0, 32'h700);
        run(1);
        push_pkt(0, 1, 1, 32'h800);
        push_pkt(1, 1, 1, 32'h900);
        do_reset(1);
        chk("p5_fsm_idle", 64'(dut.state_q), 64'(ST_IDLE));
        run(10);

        // Randomized traffic, credits, invalid flits and occasional resets
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0 && pq[r].size() < 6)
                push_pkt(r, $urandom_range(1, 3), $urandom_range(0, 1), $urandom);
            non_full_vcs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            for (int i = 0; i < N; i++) kill[i] = ($urandom_range(0, 7) == 0);
            RESET = ($urandom_range(0, 199) == 0);
            cycle();
        end
        kill  = '0;
        RESET = 1'b0;
        non_full_vcs = 2'b11;
        run(60);

`ifdef SEND_PORT_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) pq[i].delete();
        do_reset(1);
        // Alternating VCs avoid the lock so req0 is accepted every cycle
        for (int k = 0; k < 70000; k++) begin
            req_valid = 4'b0001;
            req_flit  = '0;
            req_flit[FW-1:0] = mk_flit(1, 1, 0, k % 2, 32'(k));
            @(posedge CLK);
            #1;
        end
        req_valid = '0;
        @(negedge CLK);
        chk("stat_flits0_sat", 64'(stat_flits[15:0]), 64'hFFFF);
        chk("stat_flits1", 64'(stat_flits[31:16]), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
